// File: rtl/minicpu_fetch.sv
// -----------------------------------------------------------------------------
// minicpu_fetch
//
// Instruction-fetch front end for the MiniCPU. A small program buffer is
// loaded word by word while idle. START replays it to the CPU one word per
// clock. Execution stops on a halt opcode, at the end of the loaded program,
// or on an external STOP.
//
// Parameters
//   IW      instruction width (matches the MiniCPU IN port)
//   DEPTH   program buffer entries (power of two)
//   AW      address width, log2(DEPTH)
//   HALT_OP opcode in the top nibble of a word that ends execution
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_ld_en        append i_ld_data to the buffer (IDLE only, ignored when full)
//   i_ld_data      instruction word to load
//   i_clear        empty the program (count to 0)
//   i_start        run from address 0 (needs a non-empty program)
//   i_stop         abort execution; beats i_start and halt/end detection
//   o_instr        registered instruction to the MiniCPU
//   o_instr_valid  o_instr holds a live instruction this cycle
//   o_pc           address of the next word to fetch
//   o_count        number of loaded words, 0..DEPTH
//   o_ld_full      buffer full (count == DEPTH)
//   o_busy         state is RUN
//   o_done         state is DONE
//
// Build option
//   MINICPU_FETCH_LOOP_EN  when defined, the end of the program wraps PC to 0
//                          and execution repeats without a gap cycle. A halt
//                          opcode or STOP still ends the run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module minicpu_fetch #(
  parameter int         IW      = 12,
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ld_en,
  input  logic [IW-1:0] i_ld_data,
  input  logic          i_clear,
  input  logic          i_start,
  input  logic          i_stop,
  output logic [IW-1:0] o_instr,
  output logic          o_instr_valid,
  output logic [AW-1:0] o_pc,
  output logic [AW:0]   o_count,
  output logic          o_ld_full,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_count;
  logic [IW-1:0] r_instr;
  logic          r_instr_valid;
  // Set when the final program word has just been issued; the following
  // edge retires to DONE so that INSTR is already zero while DONE is shown.
  logic          r_last;
  logic [IW-1:0] r_mem [DEPTH];

  // Next-state values
  state_t        w_state_nxt;
  logic [AW-1:0] w_pc_nxt;
  logic [AW:0]   w_count_nxt;
  logic [IW-1:0] w_instr_nxt;
  logic          w_instr_valid_nxt;
  logic          w_last_nxt;
  logic          w_mem_we;

  // Fetch datapath
  logic          w_full;
  logic          w_start_ok;
  logic          w_launch;
  logic [AW-1:0] w_fetch_addr;
  logic [IW-1:0] w_word;
  logic          w_is_halt;
  logic          w_at_end;

  // Outcome of one fetch step, shared by the launch and run paths
  state_t        w_step_state;
  logic [AW-1:0] w_step_pc;
  logic [IW-1:0] w_step_instr;
  logic          w_step_valid;
  logic          w_step_last;

  // ---------------------------------------------------------------------------
  // Fetch datapath
  // ---------------------------------------------------------------------------
  assign w_full     = (r_count == (AW+1)'(DEPTH));
  assign w_start_ok = i_start && !i_stop && (r_count != '0);

  // A START accepted from IDLE or DONE fetches address 0 on the same edge
  // that enters RUN, so the first word reaches INSTR in the cycle right
  // after the START edge and the stream has no leading bubble. CLEAR outranks
  // START in both states.
  assign w_launch     = (r_state != ST_RUN) && w_start_ok && !i_clear;
  assign w_fetch_addr = w_launch ? '0 : r_pc;
  assign w_word       = r_mem[w_fetch_addr];
  assign w_is_halt    = (w_word[IW-1 -: 4] == HALT_OP);
  // r_count is non-zero whenever a fetch is taken, so COUNT-1 cannot underflow.
  assign w_at_end     = ({1'b0, w_fetch_addr} == (r_count - (AW+1)'(1)));

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    w_step_state = ST_RUN;
    w_step_pc    = w_fetch_addr + AW'(1);
    w_step_instr = w_word;
    w_step_valid = 1'b1;
    w_step_last  = 1'b0;

    if (w_is_halt) begin
      // The halt word itself is never presented to the CPU.
      w_step_state = ST_DONE;
      w_step_pc    = w_fetch_addr;
      w_step_instr = '0;
      w_step_valid = 1'b0;
    end else if (w_at_end) begin
`ifdef MINICPU_FETCH_LOOP_EN
      w_step_pc   = '0;
`else
      // PC+1 wraps to 0 when the buffer is full; retirement is driven by
      // r_last, not by the PC value, so the wrap is harmless.
      w_step_last = 1'b1;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_count_nxt       = r_count;
    w_instr_nxt       = r_instr;
    w_instr_valid_nxt = r_instr_valid;
    w_last_nxt        = r_last;
    w_mem_we          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // CLEAR > START > LD_EN; a losing request is dropped, not queued.
        if (i_clear) begin
          w_count_nxt = '0;
        end else if (w_launch) begin
          w_state_nxt       = w_step_state;
          w_pc_nxt          = w_step_pc;
          w_instr_nxt       = w_step_instr;
          w_instr_valid_nxt = w_step_valid;
          w_last_nxt        = w_step_last;
        end else if (i_start) begin
          // START refused (empty program or STOP present): still outranks LD_EN.
        end else if (i_ld_en && !w_full) begin
          w_mem_we    = 1'b1;
          w_count_nxt = r_count + (AW+1)'(1);
        end
      end

      ST_RUN: begin
        if (i_stop) begin
          w_state_nxt       = ST_IDLE;
          w_instr_nxt       = '0;
          w_instr_valid_nxt = 1'b0;
          w_last_nxt        = 1'b0;
        end else if (r_last) begin
          w_state_nxt       = ST_DONE;
          w_instr_nxt       = '0;
          w_instr_valid_nxt = 1'b0;
          w_last_nxt        = 1'b0;
        end else begin
          w_state_nxt       = w_step_state;
          w_pc_nxt          = w_step_pc;
          w_instr_nxt       = w_step_instr;
          w_instr_valid_nxt = w_step_valid;
          w_last_nxt        = w_step_last;
        end
      end

      ST_DONE: begin
        if (i_stop || i_clear) begin
          w_state_nxt = ST_IDLE;
          if (i_clear) begin
            w_count_nxt = '0;
          end
        end else if (w_launch) begin
          w_state_nxt       = w_step_state;
          w_pc_nxt          = w_step_pc;
          w_instr_nxt       = w_step_instr;
          w_instr_valid_nxt = w_step_valid;
          w_last_nxt        = w_step_last;
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_instr_nxt       = '0;
        w_instr_valid_nxt = 1'b0;
        w_last_nxt        = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_count       <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_last        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_count       <= w_count_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_last        <= w_last_nxt;
    end
  end

  // NOTE: the program buffer has no reset; its contents are meaningless until
  // loaded and COUNT gates every read, so it can map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[r_count[AW-1:0]] <= i_ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_pc          = r_pc;
  assign o_count       = r_count;
  assign o_ld_full     = w_full;
  assign o_busy        = (r_state == ST_RUN);
  assign o_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_minicpu_fetch.sv
// -----------------------------------------------------------------------------
// tb_minicpu_fetch
//
// Self-checking bench for minicpu_fetch. Expected instruction streams are
// pushed to a scoreboard queue when a program is started and popped on every
// sampled cycle. Inputs change 1 ns after a rising edge or at a falling edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_minicpu_fetch;

  localparam int IW    = 12;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_en;
  logic [IW-1:0] ld_data;
  logic          clear;
  logic          start;
  logic          stop;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW:0]   count;
  logic          ld_full;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  logic [IW-1:0] exp_q[$];

  minicpu_fetch #(
    .IW      (IW),
    .DEPTH   (DEPTH),
    .AW      (AW),
    .HALT_OP (4'hF)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ld_en       (ld_en),
    .i_ld_data     (ld_data),
    .i_clear       (clear),
    .i_start       (start),
    .i_stop        (stop),
    .o_instr       (instr),
    .o_instr_valid (instr_valid),
    .o_pc          (pc),
    .o_count       (count),
    .o_ld_full     (ld_full),
    .o_busy        (busy),
    .o_done        (done)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus primitives
  // ---------------------------------------------------------------------------
  task automatic do_load(input logic [IW-1:0] w);
    ld_en   = 1'b1;
    ld_data = w;
    @(posedge clk);
    #1;
    ld_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Scoreboard consumer: while words are pending each sampled cycle must
  // carry the next one with VALID high; the first cycle after the last
  // word must show DONE with INSTR cleared.
  task automatic sb_drain(input string tag);
    logic [IW-1:0] exp;
    bit            fin;
    fin = 1'b0;
    for (int c = 0; c < 40 && !fin; c++) begin
      @(negedge clk);
      checks++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        if (instr_valid !== 1'b1 || instr !== exp) begin
          errors++;
          $display("FAIL %s issue %0d: got valid=%b instr=%h, want valid=1 instr=%h",
                   tag, c, instr_valid, instr, exp);
        end
      end else begin
        fin = 1'b1;
        if (done !== 1'b1 || busy !== 1'b0 || instr_valid !== 1'b0 || instr !== '0) begin
          errors++;
          $display("FAIL %s end: got done=%b busy=%b valid=%b instr=%h, want done=1 busy=0 valid=0 instr=000",
                   tag, done, busy, instr_valid, instr);
        end
      end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d words still pending", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({instr, instr_valid, pc, count, ld_full, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got instr=%h valid=%b pc=%0d count=%0d full=%b busy=%b done=%b, want all 0",
               instr, instr_valid, pc, count, ld_full, busy, done);
    end

    // START with an empty program is refused.
    pulse_start();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || instr_valid !== 1'b0 || pc !== '0) begin
      errors++;
      $display("FAIL start_empty: got busy=%b done=%b valid=%b pc=%0d, want 0 0 0 0",
               busy, done, instr_valid, pc);
    end

    // Reset while an instruction is in flight clears outputs without a clock.
    do_load(12'h100);
    do_load(12'h201);
    do_load(12'h302);
    pulse_start();
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 12'h100) begin
      errors++;
      $display("FAIL run_before_reset: got valid=%b instr=%h, want valid=1 instr=100",
               instr_valid, instr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({instr, instr_valid, pc, count, ld_full, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got instr=%h valid=%b pc=%0d count=%0d full=%b busy=%b done=%b, want all 0",
               instr, instr_valid, pc, count, ld_full, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (count !== '0 || busy !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got count=%0d busy=%b valid=%b, want 0 0 0",
               count, busy, instr_valid);
    end
  endtask

  task automatic test_halt();
    do_load(12'h100);
    do_load(12'hF00);
    do_load(12'h201);
    exp_q.push_back(12'h100);
    pulse_start();
    sb_drain("halt");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || instr !== '0 || done !== 1'b1) begin
        errors++;
        $display("FAIL halt_hold %0d: got valid=%b instr=%h done=%b, want 0 000 1",
                 c, instr_valid, instr, done);
      end
    end
    pulse_clear();
    @(negedge clk);
    checks++;
    if (count !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_from_done: got count=%0d done=%b busy=%b, want 0 0 0",
               count, done, busy);
    end
  endtask

`ifndef MINICPU_FETCH_LOOP_EN
  task automatic load_five();
    do_load(12'h000);
    do_load(12'h100);
    do_load(12'h201);
    do_load(12'h300);
    do_load(12'h400);
  endtask

  task automatic push_five();
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h100);
    exp_q.push_back(12'h201);
    exp_q.push_back(12'h300);
    exp_q.push_back(12'h400);
  endtask

  task automatic test_sequence();
    load_five();
    @(negedge clk);
    checks++;
    if (count !== 5'd5 || ld_full !== 1'b0) begin
      errors++;
      $display("FAIL seq_count: got count=%0d full=%b, want 5 0", count, ld_full);
    end
    push_five();
    pulse_start();
    sb_drain("sequence");
    checks++;
    if (pc !== 4'd5) begin
      errors++;
      $display("FAIL seq_pc: got pc=%0d, want 5", pc);
    end
    // START from DONE replays the same program.
    push_five();
    pulse_start();
    sb_drain("rerun");
    pulse_clear();
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      do_load(12'h100 + 12'(i));
    end
    @(negedge clk);
    checks++;
    if (ld_full !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL full_flag: got full=%b count=%0d, want 1 16", ld_full, count);
    end
    do_load(12'h2AA);
    @(negedge clk);
    checks++;
    if (ld_full !== 1'b1 || count !== 5'd16) begin
      errors++;
      $display("FAIL load_when_full: got full=%b count=%0d, want 1 16", ld_full, count);
    end
    // Running the whole buffer proves mem[0] was untouched and that end
    // detection precedes the PC wrap.
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(12'h100 + 12'(i));
    end
    pulse_start();
    sb_drain("full_run");
    checks++;
    if (pc !== '0) begin
      errors++;
      $display("FAIL full_pc_wrap: got pc=%0d, want 0", pc);
    end
    pulse_clear();
  endtask

  task automatic test_stop();
    logic [IW-1:0] exp;
    load_five();
    push_five();
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp) begin
        errors++;
        $display("FAIL stop_pre %0d: got valid=%b instr=%h, want valid=1 instr=%h",
                 c, instr_valid, instr, exp);
      end
    end
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || instr !== '0 || busy !== 1'b0 || done !== 1'b0 || pc !== 4'd3) begin
      errors++;
      $display("FAIL stop_state: got valid=%b instr=%h busy=%b done=%b pc=%0d, want 0 000 0 0 3",
               instr_valid, instr, busy, done, pc);
    end
    push_five();
    pulse_start();
    sb_drain("restart");
    // STOP together with START in DONE: STOP wins and returns to IDLE.
    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_stop_together: got busy=%b done=%b valid=%b, want 0 0 0",
               busy, done, instr_valid);
    end
    pulse_clear();
  endtask
`else
  task automatic test_loop();
    logic [IW-1:0] exp;
    do_load(12'h100);
    do_load(12'h201);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(12'h100);
      exp_q.push_back(12'h201);
    end
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp || busy !== 1'b1) begin
        errors++;
        $display("FAIL loop %0d: got valid=%b instr=%h busy=%b, want 1 %h 1",
                 c, instr_valid, instr, busy, exp);
      end
    end
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0 || instr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: got valid=%b instr=%h busy=%b done=%b, want 0 000 0 0",
               instr_valid, instr, busy, done);
    end
    pulse_clear();
  endtask
`endif

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  initial begin
    rst_n   = 1'b0;
    ld_en   = 1'b0;
    ld_data = '0;
    clear   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    #17 rst_n = 1'b1;

    test_reset();
    test_halt();
`ifndef MINICPU_FETCH_LOOP_EN
    test_sequence();
    test_full();
    test_stop();
`else
    test_loop();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/minicpu_fetch.md
Name: minicpu_fetch

Overview:
- Upstream instruction-fetch stage for the MiniCPU; drives its 12-bit instruction input once per clock.
- Holds a small loadable program buffer and a program counter.
- Sequences stored instructions to the CPU and stops on a halt opcode, at end of program, or on an external stop.
- Provides load/start/stop/status handshakes to the surrounding system or testbench.

Parameters:
IW, 12, instruction width; matches MiniCPU IN width
DEPTH, 16, program buffer entries (power of two)
AW, 4, address width, log2(DEPTH)
HALT_OP, 4'hF, opcode value in INSTR[11:8] that ends execution

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
LD_EN  input  1  write LD_DATA into buffer at next free slot
LD_DATA  input  IW  instruction word to load
CLEAR  input  1  empty the program (COUNT to 0)
START  input  1  begin execution from address 0
STOP  input  1  abort execution
INSTR  output  IW  registered instruction to MiniCPU IN
INSTR_VALID  output  1  INSTR holds a live instruction this cycle
PC  output  AW  address of the next word to fetch
COUNT  output  AW+1  number of loaded words, 0..DEPTH
LD_FULL  output  1  COUNT==DEPTH
BUSY  output  1  state==RUN
DONE  output  1  state==DONE

Behaviour:
- Reset (asynchronous, RST_N low) sets state IDLE and clears INSTR, INSTR_VALID, PC, COUNT, BUSY, DONE and LD_FULL to 0. Buffer contents are undefined after reset.
- States are IDLE, RUN and DONE. All transitions occur on the CLK rising edge.
- IDLE:
  - LD_EN with COUNT<DEPTH writes mem[COUNT]<=LD_DATA and increments COUNT.
  - LD_EN with LD_FULL=1 is ignored; COUNT and buffer are unchanged.
  - CLEAR sets COUNT<=0.
  - START with COUNT>0 sets PC<=0 and moves to RUN. START with COUNT==0 is ignored.
  - Priority within IDLE: CLEAR > START > LD_EN. Lower-priority requests in the same cycle are dropped, not queued.
- RUN:
  - Each cycle reads w=mem[PC].
  - If w[11:8]!=HALT_OP: INSTR<=w, INSTR_VALID<=1, PC<=PC+1.
  - If w[11:8]==HALT_OP: INSTR<=0, INSTR_VALID<=0, go to DONE. The halt word is never presented to the CPU.
  - If PC==COUNT-1 and the word is not a halt: the word is issued, then the next state is DONE.
  - Latency: first instruction appears on INSTR in the cycle after the START edge. After that, one instruction is issued per cycle with no bubbles.
  - STOP in RUN: next edge INSTR<=0, INSTR_VALID<=0, state IDLE, PC held. STOP beats halt/end detection in the same cycle.
  - LD_EN and CLEAR are ignored in RUN.
- DONE:
  - INSTR=0 and INSTR_VALID=0; DONE=1.
  - START re-runs from PC=0 with the same program.
  - CLEAR sets COUNT=0 and returns to IDLE.
  - STOP returns to IDLE.
  - LD_EN is ignored.
- PC arithmetic is modulo DEPTH. PC wrap is reachable only with COUNT==DEPTH, and end-of-program detection fires before the wrap.
- START and STOP together in any state: STOP wins.
- Reset mid-RUN drops the in-flight instruction immediately, because reset is asynchronous.

Optional Feature:
MINICPU_FETCH_LOOP_EN
- Defined: end of program (PC==COUNT-1) wraps PC to 0 and stays in RUN, so the program repeats continuously with no gap cycle. A halt opcode and STOP still terminate execution as specified in Behaviour.
- Undefined: end of program goes to DONE as specified in Behaviour.

Test Plan:
- Reset with RST_N=0 mid-cycle -> all outputs 0 immediately; release, then START alone -> stays IDLE because COUNT=0.
- Load 12'h000, 12'h100, 12'h201, 12'h300, 12'h400, then START -> INSTR shows that sequence on 5 consecutive cycles starting 1 cycle after START, INSTR_VALID=1 throughout, then DONE=1 and INSTR=0.
- Load 12'h100, 12'hF00, 12'h201, then START -> only 12'h100 is issued, then DONE; 12'h201 never appears.
- Load 16 words -> LD_FULL=1 and COUNT=16; 17th LD_EN -> COUNT stays 16 and mem[0] is unchanged.
- STOP on the 3rd issued cycle of a 5-word program -> INSTR_VALID=0 the next cycle, state IDLE, PC=3; START again -> reissues from 12'h000.
- With MINICPU_FETCH_LOOP_EN, a 2-word program 12'h100, 12'h201 -> continuous 100, 201, 100, 201...; STOP ends it.
